// File: rtl/ahb_sram_bridge.sv
// AHB-Lite slave bridging to a single-port synchronous SRAM, with a one-entry posted write
// buffer and read-after-write forwarding. Define AHB_SRAM_BRIDGE_ERR_EN for size/alignment ERROR responses.
module ahb_sram_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 10,
    parameter int RD_LATENCY = 1
) (
    input  logic                                      hclk_i,
    input  logic                                      hrst_i,
    input  logic                                      hsel_i,
    input  logic [ADDR_BITS+$clog2(DATA_WIDTH/8)-1:0] haddr_i,
    input  logic [1:0]                                htrans_i,
    input  logic                                      hwrite_i,
    input  logic [2:0]                                hsize_i,
    input  logic [DATA_WIDTH-1:0]                     hwdata_i,
    input  logic                                      hready_i,
    output logic [DATA_WIDTH-1:0]                     hrdata_o,
    output logic                                      hreadyout_o,
    output logic                                      hresp_o,
    output logic                                      mem_en_o,
    output logic                                      mem_we_o,
    output logic [DATA_WIDTH/8-1:0]                   mem_wbe_o,
    output logic [ADDR_BITS-1:0]                      mem_addr_o,
    output logic [DATA_WIDTH-1:0]                     mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]                     mem_rdata_i
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BE_W);

    typedef enum logic [1:0] {ST_IDLE, ST_RD_WAIT, ST_ERR1, ST_ERR2} state_t;

    // Lanes share a size-aligned block with the offset; oversize clamps to a full word.
    function automatic logic [BE_W-1:0] lane_mask(input logic [2:0] size, input logic [OFF_W-1:0] off);
        logic [BE_W-1:0] m;
        int              sz;
        sz = (int'(size) > OFF_W) ? OFF_W : int'(size);
        m  = {BE_W{1'b0}};
        for (int i = 0; i < BE_W; i++) begin
            m[i] = ((i ^ int'(off)) >> sz) == 32'sd0;
        end
        return m;
    endfunction

    function automatic logic size_err(input logic [2:0] size, input logic [OFF_W-1:0] off);
        if (int'(size) > OFF_W) begin
            return 1'b1;
        end else begin
            return (int'(off) & ((32'sd1 << int'(size)) - 32'sd1)) != 32'sd0;
        end
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(input logic [BE_W-1:0] be,
                                                          input logic [DATA_WIDTH-1:0] fwd,
                                                          input logic [DATA_WIDTH-1:0] mem);
        logic [DATA_WIDTH-1:0] r;
        r = mem;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) r[8*i +: 8] = fwd[8*i +: 8];
            else       r[8*i +: 8] = mem[8*i +: 8];
        end
        return r;
    endfunction

    state_t                state_r, state_s;
    logic [1:0]            wait_cnt_r, wait_cnt_s;
    logic                  accept_s, err_s, rd_issue_s, wr_accept_s, commit_s;
    logic [ADDR_BITS-1:0]  word_addr_s;
    logic [OFF_W-1:0]      off_s;
    logic [BE_W-1:0]       lanes_s, hit_s;
    logic                  pend_valid_r;
    logic [ADDR_BITS-1:0]  pend_addr_r;
    logic [BE_W-1:0]       pend_be_r;
    logic                  buf_valid_r;
    logic [ADDR_BITS-1:0]  buf_addr_r;
    logic [BE_W-1:0]       buf_be_r;
    logic [DATA_WIDTH-1:0] buf_data_r;
    logic [BE_W-1:0]       fwd_be_r;
    logic [RD_LATENCY-1:0] rd_pipe_r;
    logic                  unused_s;

    assign unused_s    = htrans_i[0];
    assign accept_s    = hsel_i & hready_i & htrans_i[1] & ~hrst_i;
    assign word_addr_s = haddr_i[ADDR_BITS+OFF_W-1:OFF_W];
    assign off_s       = haddr_i[OFF_W-1:0];
    assign lanes_s     = lane_mask(hsize_i, off_s);
`ifdef AHB_SRAM_BRIDGE_ERR_EN
    assign err_s       = accept_s & size_err(hsize_i, off_s);
`else
    assign err_s       = 1'b0;
`endif
    assign rd_issue_s  = accept_s & ~hwrite_i & ~err_s;
    assign wr_accept_s = accept_s & hwrite_i & ~err_s;
    // A write in its data phase never coexists with a valid buffer, so one port suffices.
    assign commit_s    = ~rd_issue_s & (pend_valid_r | buf_valid_r);

    // Forwarding hit: the write whose data arrives now, else the held buffer entry.
    always_comb begin
        hit_s = {BE_W{1'b0}};
        if (pend_valid_r && (pend_addr_r == word_addr_s)) begin
            hit_s = pend_be_r;
        end else if (buf_valid_r && (buf_addr_r == word_addr_s)) begin
            hit_s = buf_be_r;
        end else begin
            hit_s = {BE_W{1'b0}};
        end
    end

    // SRAM port: reads win; a commit takes any cycle without a read issue.
    always_comb begin
        mem_en_o    = rd_issue_s | commit_s;
        mem_we_o    = commit_s;
        mem_addr_o  = {ADDR_BITS{1'b0}};
        mem_wbe_o   = {BE_W{1'b0}};
        mem_wdata_o = {DATA_WIDTH{1'b0}};
        if (rd_issue_s) begin
            mem_addr_o = word_addr_s;
        end else if (commit_s && pend_valid_r) begin
            mem_addr_o  = pend_addr_r;
            mem_wbe_o   = pend_be_r;
            mem_wdata_o = hwdata_i;
        end else if (commit_s) begin
            mem_addr_o  = buf_addr_r;
            mem_wbe_o   = buf_be_r;
            mem_wdata_o = buf_data_r;
        end else begin
            mem_addr_o = {ADDR_BITS{1'b0}};
        end
    end

    assign hrdata_o = rd_pipe_r[RD_LATENCY-1] ? merge_lanes(fwd_be_r, buf_data_r, mem_rdata_i)
                                              : {DATA_WIDTH{1'b0}};

    // Write address stage, posted buffer, forwarding mask and read-return tracking.
    always_ff @(posedge hclk_i or posedge hrst_i) begin
        if (hrst_i) begin
            pend_valid_r <= 1'b0;
            pend_addr_r  <= {ADDR_BITS{1'b0}};
            pend_be_r    <= {BE_W{1'b0}};
            buf_valid_r  <= 1'b0;
            buf_addr_r   <= {ADDR_BITS{1'b0}};
            buf_be_r     <= {BE_W{1'b0}};
            buf_data_r   <= {DATA_WIDTH{1'b0}};
            fwd_be_r     <= {BE_W{1'b0}};
            rd_pipe_r    <= {RD_LATENCY{1'b0}};
        end else begin
            pend_valid_r <= wr_accept_s;
            if (wr_accept_s) begin
                pend_addr_r <= word_addr_s;
                pend_be_r   <= lanes_s;
            end
            if (pend_valid_r && rd_issue_s) begin
                buf_valid_r <= 1'b1;
                buf_addr_r  <= pend_addr_r;
                buf_be_r    <= pend_be_r;
                buf_data_r  <= hwdata_i;
            end else if (commit_s) begin
                buf_valid_r <= 1'b0;
            end
            if (rd_issue_s) begin
                fwd_be_r <= hit_s;
            end
            rd_pipe_r <= (rd_pipe_r << 1'b1) | RD_LATENCY'(rd_issue_s);
        end
    end

    // FSM state and wait counter registers.
    always_ff @(posedge hclk_i or posedge hrst_i) begin
        if (hrst_i) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 2'd0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
        end
    end

    // FSM next state and bus handshake outputs.
    always_comb begin
        state_s     = state_r;
        wait_cnt_s  = wait_cnt_r;
        hreadyout_o = 1'b1;
        hresp_o     = 1'b0;
        case (state_r)
            ST_IDLE, ST_ERR2: begin
                hresp_o = (state_r == ST_ERR2);
                if (err_s) begin
                    state_s = ST_ERR1;
                end else if (rd_issue_s && (RD_LATENCY > 1)) begin
                    state_s    = ST_RD_WAIT;
                    wait_cnt_s = 2'(RD_LATENCY - 2);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                hreadyout_o = 1'b0;
                if (wait_cnt_r == 2'd0) begin
                    state_s = ST_IDLE;
                end else begin
                    wait_cnt_s = wait_cnt_r - 2'd1;
                end
            end
            ST_ERR1: begin
                hreadyout_o = 1'b0;
                hresp_o     = 1'b1;
                state_s     = ST_ERR2;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_ahb_sram_bridge.sv
// Bench for ahb_sram_bridge: directed steps plus random traffic against a byte-level memory model,
// on one RD_LATENCY=1 instance (index 0) and one RD_LATENCY=3 instance (index 1).
module tb_ahb_sram_bridge;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        hsel [2];
    logic [1:0]  htrans [2];
    logic        hwrite [2];
    logic [2:0]  hsize [2];
    logic [11:0] haddr [2];
    logic [31:0] hwdata [2];
    logic [31:0] hrdata [2];
    logic        hreadyout [2];
    logic        hresp [2];
    logic        mem_en [2];
    logic        mem_we [2];
    logic [3:0]  mem_wbe [2];
    logic [9:0]  mem_addr [2];
    logic [31:0] mem_wdata [2];

    logic [31:0] sram [2][1024];
    logic [31:0] refm [2][1024];
    logic [31:0] rpipe [2][3];
    logic [3:0]  last_wbe [2];
    logic [9:0]  last_waddr [2];
    int          wr_cnt [2];
    int          en_cnt [2];

    int errors = 0;
    int checks = 0;

    bit          pw_v [2];
    logic [11:0] pw_a [2];
    logic [2:0]  pw_s [2];
    logic [31:0] pw_d [2];
    bit          pr_v [2];
    logic [31:0] pr_e [2];
    int          last_wait [2];

    ahb_sram_bridge #(.DATA_WIDTH(32), .ADDR_BITS(10), .RD_LATENCY(1)) u_dut (
        .hclk_i(clk), .hrst_i(rst), .hsel_i(hsel[0]), .haddr_i(haddr[0]), .htrans_i(htrans[0]),
        .hwrite_i(hwrite[0]), .hsize_i(hsize[0]), .hwdata_i(hwdata[0]), .hready_i(hreadyout[0]),
        .hrdata_o(hrdata[0]), .hreadyout_o(hreadyout[0]), .hresp_o(hresp[0]),
        .mem_en_o(mem_en[0]), .mem_we_o(mem_we[0]), .mem_wbe_o(mem_wbe[0]), .mem_addr_o(mem_addr[0]),
        .mem_wdata_o(mem_wdata[0]), .mem_rdata_i(rpipe[0][0])
    );

    ahb_sram_bridge #(.DATA_WIDTH(32), .ADDR_BITS(10), .RD_LATENCY(3)) u_dut_l3 (
        .hclk_i(clk), .hrst_i(rst), .hsel_i(hsel[1]), .haddr_i(haddr[1]), .htrans_i(htrans[1]),
        .hwrite_i(hwrite[1]), .hsize_i(hsize[1]), .hwdata_i(hwdata[1]), .hready_i(hreadyout[1]),
        .hrdata_o(hrdata[1]), .hreadyout_o(hreadyout[1]), .hresp_o(hresp[1]),
        .mem_en_o(mem_en[1]), .mem_we_o(mem_we[1]), .mem_wbe_o(mem_wbe[1]), .mem_addr_o(mem_addr[1]),
        .mem_wdata_o(mem_wdata[1]), .mem_rdata_i(rpipe[1][2])
    );

    // SRAM macro models with 3-deep read pipes, plus commit/enable monitors.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_en[d] && mem_we[d]) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wbe[d][b]) sram[d][mem_addr[d]][8*b +: 8] <= mem_wdata[d][8*b +: 8];
                end
                last_wbe[d]   <= mem_wbe[d];
                last_waddr[d] <= mem_addr[d];
                wr_cnt[d]     <= wr_cnt[d] + 1;
            end
            if (mem_en[d]) en_cnt[d] <= en_cnt[d] + 1;
            rpipe[d][0] <= (mem_en[d] && !mem_we[d]) ? sram[d][mem_addr[d]] : 32'hDEAD_BEEF;
            rpipe[d][1] <= rpipe[d][0];
            rpipe[d][2] <= rpipe[d][1];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Architectural write: size-aligned block of 2**size bytes (capped at the word), little-endian.
    task automatic ref_write(input int d, input logic [11:0] a, input logic [2:0] sz, input logic [31:0] wd);
        int n;
        int base;
        n    = (sz >= 3'd2) ? 4 : (1 << sz);
        base = (int'(a[1:0]) / n) * n;
        for (int b = base; b < base + n; b++) refm[d][a[11:2]][8*b +: 8] = wd[8*b +: 8];
    endtask

    // One bus cycle: present an address phase, supply the previous write's data, check the previous read.
    task automatic cyc(input int d, input bit act, input bit wr, input logic [2:0] sz,
                       input logic [11:0] a, input logic [31:0] wd);
        bit          nrd;
        logic [31:0] nexp;
        int          w;
        hsel[d]   = act;
        htrans[d] = act ? 2'b10 : 2'b00;
        hwrite[d] = wr;
        hsize[d]  = sz;
        haddr[d]  = a;
        hwdata[d] = pw_v[d] ? pw_d[d] : $urandom();
        if (pw_v[d]) ref_write(d, pw_a[d], pw_s[d], pw_d[d]);
        nrd  = act && !wr;
        nexp = refm[d][a[11:2]];
        w    = 0;
        @(negedge clk);
        while (!hreadyout[d] && w < 16) begin
            w++;
            @(negedge clk);
        end
        if (w >= 16) check("ready_timeout", 64'(w), 64'd0);
        last_wait[d] = w;
        if (pr_v[d]) check("rdata", hrdata[d], pr_e[d]);
        check("hresp_okay", hresp[d], 1'b0);
        @(posedge clk);
        #1;
        pr_v[d] = nrd;
        pr_e[d] = nexp;
        pw_v[d] = act && wr;
        pw_a[d] = a;
        pw_s[d] = sz;
        pw_d[d] = wd;
    endtask

    task automatic idle(input int d, input int n);
        for (int i = 0; i < n; i++) cyc(d, 1'b0, 1'b0, 3'd0, 12'h000, 32'h0);
    endtask

    task automatic rand_ops(input int d, input int n);
        logic [2:0]  sz;
        logic [11:0] a;
        for (int i = 0; i < n; i++) begin
            sz = 3'($urandom_range(0, 2));
            a  = 12'($urandom_range(0, 15) * 4);
            if (sz == 3'd0) a = a + 12'($urandom_range(0, 3));
            if (sz == 3'd1) a = a + 12'($urandom_range(0, 1) * 2);
            cyc(d, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), sz, a, $urandom());
        end
    endtask

    initial begin
        logic [31:0] old5;
        int          snap_wr;
        int          snap_en;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 1024; i++) begin
                sram[d][i] = {4{8'(i)}} ^ 32'h5A00_0000;
                refm[d][i] = {4{8'(i)}} ^ 32'h5A00_0000;
            end
            for (int k = 0; k < 3; k++) rpipe[d][k] = 32'h0;
            hsel[d] = 1'b0; htrans[d] = 2'b00; hwrite[d] = 1'b0; hsize[d] = 3'd0;
            haddr[d] = 12'h0; hwdata[d] = 32'h0;
            pw_v[d] = 1'b0; pr_v[d] = 1'b0; wr_cnt[d] = 0; en_cnt[d] = 0;
            last_wbe[d] = 4'h0; last_waddr[d] = 10'h0;
        end
        #1 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_hreadyout", hreadyout[d], 1'b1);
            check("rst_hresp", hresp[d], 1'b0);
            check("rst_hrdata", hrdata[d], 32'h0);
            check("rst_mem_en", mem_en[d], 1'b0);
            check("rst_mem_we", mem_we[d], 1'b0);
            check("rst_mem_wbe", mem_wbe[d], 4'h0);
            check("rst_mem_addr", mem_addr[d], 10'h0);
            check("rst_mem_wdata", mem_wdata[d], 32'h0);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Zero-wait read of word 4.
        cyc(0, 1'b1, 1'b0, 3'd2, 12'h010, 32'h0);
        idle(0, 1);
        check("rd_lat1_wait", last_wait[0], 0);

        // Write then immediate read of the same word is forwarded.
        cyc(0, 1'b1, 1'b1, 3'd2, 12'h020, 32'hA5A5_A5A5);
        cyc(0, 1'b1, 1'b0, 3'd2, 12'h020, 32'h0);
        idle(0, 2);
        check("raw_sram_later", sram[0][8], 32'hA5A5_A5A5);

        // Byte write to lane 3, read back, commit lane mask.
        cyc(0, 1'b1, 1'b1, 3'd2, 12'h020, 32'h1122_3344);
        cyc(0, 1'b1, 1'b1, 3'd0, 12'h023, 32'hEE00_0000);
        cyc(0, 1'b1, 1'b0, 3'd2, 12'h020, 32'h0);
        idle(0, 2);
        check("byte_wbe", last_wbe[0], 4'b1000);
        check("byte_waddr", last_waddr[0], 10'd8);
        check("byte_sram", sram[0][8], 32'hEE22_3344);

`ifdef AHB_SRAM_BRIDGE_ERR_EN
        // Misaligned halfword write gets the two-cycle ERROR response and no SRAM access.
        snap_en = en_cnt[0];
        hsel[0] = 1'b1; htrans[0] = 2'b10; hwrite[0] = 1'b1; hsize[0] = 3'd1; haddr[0] = 12'h001;
        @(negedge clk);
        check("err_addr_ready", hreadyout[0], 1'b1);
        @(posedge clk);
        #1 hsel[0] = 1'b0; htrans[0] = 2'b00;
        @(negedge clk);
        check("err1_ready", hreadyout[0], 1'b0);
        check("err1_resp", hresp[0], 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("err2_ready", hreadyout[0], 1'b1);
        check("err2_resp", hresp[0], 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("err_after_resp", hresp[0], 1'b0);
        check("err_no_mem_en", en_cnt[0], snap_en);
        @(posedge clk);
        #1;
`else
        // Oversize treated as a full word; unaligned low address bits dropped.
        cyc(0, 1'b1, 1'b1, 3'd3, 12'h030, 32'hCAFE_F00D);
        cyc(0, 1'b1, 1'b1, 3'd2, 12'h036, 32'h0123_4567);
        cyc(0, 1'b1, 1'b0, 3'd2, 12'h030, 32'h0);
        cyc(0, 1'b1, 1'b0, 3'd2, 12'h034, 32'h0);
        idle(0, 1);
        check("oversize_word", refm[0][12], 32'hCAFE_F00D);
        check("unaligned_word", sram[0][13], 32'h0123_4567);
`endif

        // Reset with a write held in the buffer: it must never reach the SRAM.
        old5    = refm[0][5];
        snap_wr = wr_cnt[0];
        cyc(0, 1'b1, 1'b1, 3'd2, 12'h014, 32'h7777_8888);
        cyc(0, 1'b1, 1'b0, 3'd2, 12'h040, 32'h0);
        haddr[0] = 12'h044;
        #2 rst = 1'b1;
        #1;
        check("rstmid_hreadyout", hreadyout[0], 1'b1);
        check("rstmid_hresp", hresp[0], 1'b0);
        check("rstmid_hrdata", hrdata[0], 32'h0);
        check("rstmid_mem_en", mem_en[0], 1'b0);
        check("rstmid_mem_we", mem_we[0], 1'b0);
        hsel[0] = 1'b0; htrans[0] = 2'b00;
        pr_v[0] = 1'b0; pw_v[0] = 1'b0;
        refm[0][5] = old5;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(0, 3);
        check("rstmid_no_commit", wr_cnt[0], snap_wr);
        check("rstmid_sram", sram[0][5], old5);

        rand_ops(0, 400);
        idle(0, 3);

        // RD_LATENCY=3: two wait states, data from SRAM, forwarding across the stall.
        cyc(1, 1'b1, 1'b0, 3'd2, 12'h01C, 32'h0);
        idle(1, 1);
        check("lat3_wait", last_wait[1], 2);
        cyc(1, 1'b1, 1'b1, 3'd2, 12'h008, 32'h1357_9BDF);
        cyc(1, 1'b1, 1'b0, 3'd2, 12'h008, 32'h0);
        idle(1, 1);
        check("lat3_fwd_wait", last_wait[1], 2);
        rand_ops(1, 120);
        idle(1, 4);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 20; i++) check("sram_final", sram[d][i], refm[d][i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
